// File: rtl/mem_arb_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the memory-port arbiter |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

   localparam int NUM_REQ = 3;

   typedef logic [1:0] req_id_t;

   localparam req_id_t REQ_IFETCH = 2'd0;
   localparam req_id_t REQ_DATA   = 2'd1;
   localparam req_id_t REQ_IO     = 2'd2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// +----------------------------------------------------------------------+
// | rr_priority_picker : round-robin winner select, search from last+1   |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_priority_picker
   import mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid,
   input  req_id_t            last_grant,
   output logic [NUM_REQ-1:0] grant,
   output req_id_t            grant_id
);

   always_comb begin
      int   start;
      int   idx;
      logic found;
      grant    = '0;
      grant_id = REQ_IFETCH;
      found    = 1'b0;
      start    = (int'(last_grant) + 1) % NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (start + k) % NUM_REQ;
         if (!found && valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = req_id_t'(idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter : shares one cache port among three requesters      |
// | Optional ISSUE timeout enabled by MEM_ARB_TIMEOUT_EN. Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_rdata,
   output logic                      resp_err,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic [ADDR_W-1:0]         mem_address,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic                      mem_ack,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      busy,
   output req_id_t                   grant_id
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   arb_state_t          state_q,      state_d;
   req_id_t             last_grant_q, last_grant_d;
   req_id_t             id_q,         id_d;
   logic                wr_q,         wr_d;
   logic [ADDR_W-1:0]   addr_q,       addr_d;
   logic [DATA_W-1:0]   wdata_q,      wdata_d;
   logic                mem_read_q,   mem_read_d;
   logic                mem_write_q,  mem_write_d;
   logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                resp_err_q,   resp_err_d;
`ifdef MEM_ARB_TIMEOUT_EN
   logic [7:0]          cnt_q,        cnt_d;
`endif

   logic [NUM_REQ-1:0]  pick_grant;
   req_id_t             pick_id;

   rr_priority_picker u_picker (
      .valid      (req_valid),
      .last_grant (last_grant_q),
      .grant      (pick_grant),
      .grant_id   (pick_id)
   );

   // Acceptance is combinational; suppressed during reset so nothing is lost.
   assign req_ready = (state_q == IDLE && !reset) ? pick_grant : '0;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      resp_valid_d = '0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (|pick_grant) begin
               state_d      = ISSUE;
               id_d         = pick_id;
               last_grant_d = pick_id;
               wr_d         = req_write[pick_id];
               addr_d       = req_addr[int'(pick_id)*ADDR_W +: ADDR_W];
               wdata_d      = req_wdata[int'(pick_id)*DATA_W +: DATA_W];
               mem_read_d   = !req_write[pick_id];
               mem_write_d  = req_write[pick_id];
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_d        = 8'd0;
`endif
            end
         end
         ISSUE: begin
            if (mem_ack) begin
               state_d          = IDLE;
               mem_read_d       = 1'b0;
               mem_write_d      = 1'b0;
               resp_valid_d[id_q] = 1'b1;
               resp_rdata_d     = wr_q ? '0 : mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               // Final allowed ISSUE cycle expired without an ack: abort.
               state_d          = IDLE;
               mem_read_d       = 1'b0;
               mem_write_d      = 1'b0;
               resp_valid_d[id_q] = 1'b1;
               resp_err_d       = 1'b1;
            end else begin
               cnt_d            = cnt_q + 8'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= REQ_IO;
         id_q         <= REQ_IFETCH;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         resp_valid_q <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q        <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;
   assign busy        = (state_q == ISSUE);
   assign grant_id    = id_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench for the arbiter   |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    req_valid;
   logic [2:0]    req_ready;
   logic [2:0]    req_write;
   logic [191:0]  req_addr;
   logic [191:0]  req_wdata;
   logic [2:0]    resp_valid;
   logic [63:0]   resp_rdata;
   logic          resp_err;
   logic          mem_read;
   logic          mem_write;
   logic [63:0]   mem_address;
   logic [63:0]   mem_wdata;
   logic          mem_ack;
   logic [63:0]   mem_rdata;
   logic          busy;
   logic [1:0]    grant_id;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W         (64),
      .DATA_W         (64),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .busy        (busy),
      .grant_id    (grant_id)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      tick(); tick();
      #1;
      chk("rst_ready",   64'(req_ready), 64'h0);
      chk("rst_rvalid",  64'(resp_valid), 64'h0);
      chk("rst_rdata",   resp_rdata, 64'h0);
      chk("rst_err",     64'(resp_err), 64'h0);
      chk("rst_mread",   64'(mem_read), 64'h0);
      chk("rst_mwrite",  64'(mem_write), 64'h0);
      chk("rst_addr",    mem_address, 64'h0);
      chk("rst_wdata",   mem_wdata, 64'h0);
      chk("rst_busy",    64'(busy), 64'h0);
      chk("rst_gid",     64'(grant_id), 64'h0);

      // Single read from ID1
      tick();
      reset = 1'b0;
      req_valid = 3'b010; req_write = 3'b000; req_addr[64 +: 64] = 64'h100;
      #1 chk("rd_ready_T", 64'(req_ready), 64'h2);
      tick();
      req_valid = 3'b000;
      #1;
      chk("rd_mread_T1", 64'(mem_read), 64'h1);
      chk("rd_addr_T1",  mem_address, 64'h100);
      chk("rd_busy_T1",  64'(busy), 64'h1);
      chk("rd_gid_T1",   64'(grant_id), 64'h1);
      tick();
      chk("rd_mread_T2", 64'(mem_read), 64'h1);
      tick();
      mem_ack = 1'b1; mem_rdata = 64'hDEAD;
      #1 chk("rd_rvalid_T3", 64'(resp_valid), 64'h0);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("rd_rvalid_T4", 64'(resp_valid), 64'h2);
      chk("rd_rdata_T4",  resp_rdata, 64'hDEAD);
      chk("rd_err_T4",    64'(resp_err), 64'h0);
      chk("rd_mread_T4",  64'(mem_read), 64'h0);
      chk("rd_busy_T4",   64'(busy), 64'h0);
      tick();
      chk("rd_rvalid_T5", 64'(resp_valid), 64'h0);
      chk("rd_gid_hold",  64'(grant_id), 64'h1);

      // Write from ID2; ack carries junk read data that must not appear
      req_valid = 3'b100; req_write = 3'b100;
      req_addr[128 +: 64] = 64'h2000; req_wdata[128 +: 64] = 64'h55;
      #1 chk("wr_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = 3'b000; req_write = 3'b000;
      mem_ack = 1'b1; mem_rdata = 64'hBEEF;
      #1;
      chk("wr_mwrite", 64'(mem_write), 64'h1);
      chk("wr_mread",  64'(mem_read), 64'h0);
      chk("wr_wdata",  mem_wdata, 64'h55);
      chk("wr_addr",   mem_address, 64'h2000);
      chk("wr_gid",    64'(grant_id), 64'h2);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("wr_rvalid", 64'(resp_valid), 64'h4);
      chk("wr_rdata",  resp_rdata, 64'h0);
      chk("wr_err",    64'(resp_err), 64'h0);
      chk("wr_mwrite_off", 64'(mem_write), 64'h0);

      // Stray ack while idle
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1;
      chk("idle_ack_rvalid", 64'(resp_valid), 64'h0);
      chk("idle_ack_busy",   64'(busy), 64'h0);

      // Reset while ID0 outstanding, with a coincident ack
      req_valid = 3'b001; req_addr[0 +: 64] = 64'h300;
      #1 chk("rst_mid_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = 3'b000;
      #1 chk("rst_mid_mread", 64'(mem_read), 64'h1);
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 64'h1234;
      tick();
      reset = 1'b0; mem_ack = 1'b0;
      #1;
      chk("rst_mid_mread_off", 64'(mem_read), 64'h0);
      chk("rst_mid_busy",      64'(busy), 64'h0);
      chk("rst_mid_rvalid",    64'(resp_valid), 64'h0);

      // Round-robin with all three requesters valid
      req_valid = 3'b111; req_write = 3'b000;
      req_addr[0 +: 64] = 64'hA0; req_addr[64 +: 64] = 64'hA1; req_addr[128 +: 64] = 64'hA2;
      for (int i = 0; i < 6; i++) begin
         #1 chk($sformatf("rr_ready_%0d", i), 64'(req_ready), 64'(3'b001 << (i % 3)));
         tick();
         if (i == 5) req_valid = 3'b000;
         mem_ack = 1'b1; mem_rdata = 64'h1000 + 64'(i);
         #1;
         chk($sformatf("rr_gid_%0d", i),  64'(grant_id), 64'(i % 3));
         chk($sformatf("rr_addr_%0d", i), mem_address, 64'hA0 + 64'(i % 3));
         chk($sformatf("rr_issue_ready_%0d", i), 64'(req_ready), 64'h0);
         tick();
         mem_ack = 1'b0;
         #1;
         chk($sformatf("rr_rvalid_%0d", i), 64'(resp_valid), 64'(3'b001 << (i % 3)));
         chk($sformatf("rr_rdata_%0d", i),  resp_rdata, 64'h1000 + 64'(i));
      end
      chk("rr_end_ready", 64'(req_ready), 64'h0);

      // ID0 arrives while ID1 is in ISSUE
      tick();
      req_valid = 3'b010; req_addr[64 +: 64] = 64'h400;
      #1 chk("mw_ready1", 64'(req_ready), 64'h2);
      tick();
      req_valid = 3'b001; req_addr[0 +: 64] = 64'h500;
      #1 chk("mw_block_a", 64'(req_ready), 64'h0);
      tick();
      mem_ack = 1'b1; mem_rdata = 64'h77;
      #1 chk("mw_block_b", 64'(req_ready), 64'h0);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("mw_rvalid1", 64'(resp_valid), 64'h2);
      chk("mw_rdata1",  resp_rdata, 64'h77);
      chk("mw_ready0",  64'(req_ready), 64'h1);
      tick();
      req_valid = 3'b000;
      mem_ack = 1'b1; mem_rdata = 64'h88;
      #1;
      chk("mw_gid0",  64'(grant_id), 64'h0);
      chk("mw_addr0", mem_address, 64'h500);
      tick();
      mem_ack = 1'b0;
      #1 chk("mw_rvalid0", 64'(resp_valid), 64'h1);

      // Long ISSUE wait: abort after 4 cycles when enabled, otherwise wait forever
      tick();
      req_valid = 3'b001; req_addr[0 +: 64] = 64'h600;
      #1 chk("to_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = 3'b000;
`ifdef MEM_ARB_TIMEOUT_EN
      for (int c = 1; c <= 4; c++) begin
         #1 chk($sformatf("to_mread_c%0d", c), 64'(mem_read), 64'h1);
         tick();
      end
      #1;
      chk("to_mread_off", 64'(mem_read), 64'h0);
      chk("to_rvalid",    64'(resp_valid), 64'h1);
      chk("to_err",       64'(resp_err), 64'h1);
      chk("to_rdata",     resp_rdata, 64'h0);
      tick();
      req_valid = 3'b001;
      #1 chk("to2_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = 3'b000;
      tick(); tick(); tick();
      mem_ack = 1'b1; mem_rdata = 64'h99;
      tick();
      mem_ack = 1'b0;
      #1;
      chk("to2_rvalid", 64'(resp_valid), 64'h1);
      chk("to2_err",    64'(resp_err), 64'h0);
      chk("to2_rdata",  resp_rdata, 64'h99);
`else
      for (int c = 1; c <= 10; c++) tick();
      #1;
      chk("nt_mread", 64'(mem_read), 64'h1);
      chk("nt_busy",  64'(busy), 64'h1);
      chk("nt_rvalid", 64'(resp_valid), 64'h0);
      mem_ack = 1'b1; mem_rdata = 64'h99;
      tick();
      mem_ack = 1'b0;
      #1;
      chk("nt_resp",  64'(resp_valid), 64'h1);
      chk("nt_err",   64'(resp_err), 64'h0);
      chk("nt_rdata", resp_rdata, 64'h99);
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
